zap_thumb_fetch_aligner: RTL and testbench
==========================================

# zap_thumb_fetch_aligner

Fetch-side producer feeding the 16-bit (Thumb) decode stage. It takes 32-bit words from the I-cache/fetch path and presents one instruction per cycle, with PC, abort, predictor and taken status, to the Thumb decoder stage. In Thumb state it splits each fetched word into halfwords and buffers the upper halfword so it issues without a refetch. It obeys the same stall/clear priority chain as every other front-end pipeline register.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode  in  1 each  pipeline control
- i_cpsr_ff_t  in  1  current T bit
- i_word  in  32  fetched word
- i_word_valid  in  1  word qualifier
- i_word_pc  in  32  address of first instruction in i_word; bit 1 selects the halfword in Thumb state
- i_iabort  in  1  fetch abort for i_word
- i_taken  in  2  predictor state for the instruction at i_word_pc (00 SNT, 01 WNT, 10 WT, 11 ST)
- i_pred  in  33  predicted target for that instruction
- o_word_ready  out  1  aligner accepts i_word this cycle
- o_instruction  out  32  word (ARM) or zero-extended halfword (Thumb)
- o_instruction_valid  out  1  output qualifier
- o_iabort  out  1  abort for the output instruction
- o_pc_ff  out  32  instruction address
- o_pc_plus_8_ff  out  32  architectural PC read value
- o_taken_ff  out  2  predictor state
- o_pred  out  33  predicted target

## Operation
- States: EMPTY (no buffered halfword), HOLD (upper halfword, its PC and i_pred buffered).
- Priority per clock, highest first: i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode, advance.
- Reset: all outputs 0; o_instruction_valid 0; state EMPTY.
- Clear (any of the three): o_instruction_valid, o_iabort forced 0; state EMPTY; input word dropped; other outputs hold.
- Stall (any of the four stall inputs): all registers hold.
- o_word_ready = (state == EMPTY) & ~(i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode). Combinational; no dependence on i_word_valid.
- Advance, state EMPTY, i_word_valid=0: o_instruction_valid <= 0.
- Advance, state EMPTY, T=0: o_instruction <= i_word; o_pc_ff <= i_word_pc; o_pc_plus_8_ff <= i_word_pc+8; o_iabort, o_taken_ff, o_pred from inputs; valid 1.
- Advance, state EMPTY, T=1: o_instruction <= {16'd0, i_word_pc[1] ? i_word[31:16] : i_word[15:0]}; o_pc_ff <= i_word_pc; o_pc_plus_8_ff <= i_word_pc+4; other fields from inputs; valid 1.
  - Enter HOLD with upper halfword, PC i_word_pc+2 and i_pred only if i_word_pc[1]=0, i_iabort=0 and i_taken[1]=0.
  - Otherwise stay EMPTY; the upper halfword is discarded.
- Advance, state HOLD, T=1: emit the buffered halfword; o_pc_ff <= buffered PC; o_pc_plus_8_ff <= buffered PC+4; o_iabort <= 0; o_taken_ff <= 2'b01; o_pred <= buffered pred; valid 1; state EMPTY. i_word is not accepted this cycle.
- Advance, state HOLD, T=0: buffer dropped; valid 0; state EMPTY.
- PC arithmetic is modulo 2^32; a PC of 0xFFFFFFFC in Thumb yields buffered PC 0xFFFFFFFE and pc_plus_8 wraps to 0x00000002.

## Timing
- Latency: one clock, from an accepted word to its first instruction on the outputs.
- Throughput: one instruction per unstalled cycle in both states.
- Buffer reuse costs no fetch bubble: the HOLD cycle overlaps the next fetch request.
- A clear in the same cycle as a stall: the higher-priority input wins per the list above. i_data_stall above i_clear_from_alu means an ALU clear is deferred while the data stall is held.
- Reset mid-HOLD: the buffer is lost; state EMPTY next cycle.

## Configuration
- ZAP_THUMB_HW_REUSE_EN defined: HOLD state implemented as above.
- Not defined: HOLD is never entered; the upper halfword is always discarded. Fetch must re-request the word at PC+2, and o_word_ready depends on stalls only.
- ARM behaviour is identical in both builds.

## Test plan
- Reset for 3 cycles, then release -> all outputs 0, o_word_ready 1 with no stalls.
- T=1, word 0xB5104A03 at pc 0x100, not taken -> cycle 1: instr 0x00004A03, pc 0x100, pc+8 0x104. Cycle 2: instr 0x0000B510, pc 0x102, taken 01, o_word_ready 0 during HOLD. Without the macro, cycle 2 valid 0.
- T=1, pc 0x100, i_taken 2'b10 -> one instruction emitted, state stays EMPTY, o_word_ready 1 next cycle.
- T=1, pc 0x200, i_iabort 1 -> one output with o_iabort 1, no HOLD. Then a word at pc 0x202 -> upper halfword emitted, pc 0x202.
- In HOLD, assert i_stall_from_issue for 2 cycles, then i_clear_from_decode -> outputs frozen for 2 cycles, then valid 0 and state EMPTY.
- T=0, word 0xE3A00001 at pc 0xFFFFFFF8 -> instr 0xE3A00001, pc+8 0x00000000. Simultaneous i_data_stall and i_clear_from_alu -> outputs hold.

Source files
------------

// File: rtl/zap_thumb_fetch_aligner.sv
// Thumb fetch aligner: turns fetched 32-bit words into one ARM word or Thumb halfword per cycle.
// Define ZAP_THUMB_HW_REUSE_EN to buffer the upper halfword (HOLD state) instead of refetching it.
module zap_thumb_fetch_aligner (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic        i_cpsr_ff_t,
    input  logic [31:0] i_word,
    input  logic        i_word_valid,
    input  logic [31:0] i_word_pc,
    input  logic        i_iabort,
    input  logic [1:0]  i_taken,
    input  logic [32:0] i_pred,
    output logic        o_word_ready,
    output logic [31:0] o_instruction,
    output logic        o_instruction_valid,
    output logic        o_iabort,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken_ff,
    output logic [32:0] o_pred
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] instr_r, instr_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        iabort_r, iabort_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] pc8_r, pc8_nxt_s;
    logic [1:0]  taken_r, taken_nxt_s;
    logic [32:0] pred_r, pred_nxt_s;
    logic        stall_s;
`ifdef ZAP_THUMB_HW_REUSE_EN
    logic [15:0] buf_half_r, buf_half_nxt_s;
    logic [31:0] buf_pc_r, buf_pc_nxt_s;
    logic [32:0] buf_pred_r, buf_pred_nxt_s;
`endif

    assign stall_s = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;

`ifdef ZAP_THUMB_HW_REUSE_EN
    assign o_word_ready = (state_r == EMPTY) & ~stall_s;
`else
    assign o_word_ready = ~stall_s;
`endif

    assign o_instruction       = instr_r;
    assign o_instruction_valid = valid_r;
    assign o_iabort            = iabort_r;
    assign o_pc_ff             = pc_r;
    assign o_pc_plus_8_ff      = pc8_r;
    assign o_taken_ff          = taken_r;
    assign o_pred              = pred_r;

    // Next-state and next-output logic following the clear/stall priority chain.
    always_comb begin
        state_nxt_s  = state_r;
        instr_nxt_s  = instr_r;
        valid_nxt_s  = valid_r;
        iabort_nxt_s = iabort_r;
        pc_nxt_s     = pc_r;
        pc8_nxt_s    = pc8_r;
        taken_nxt_s  = taken_r;
        pred_nxt_s   = pred_r;
`ifdef ZAP_THUMB_HW_REUSE_EN
        buf_half_nxt_s = buf_half_r;
        buf_pc_nxt_s   = buf_pc_r;
        buf_pred_nxt_s = buf_pred_r;
`endif
        if (i_clear_from_writeback || (!i_data_stall && i_clear_from_alu) ||
            (!stall_s && i_clear_from_decode)) begin
            valid_nxt_s  = 1'b0;
            iabort_nxt_s = 1'b0;
            state_nxt_s  = EMPTY;
        end else if (stall_s) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (!i_word_valid) begin
                        valid_nxt_s = 1'b0;
                    end else begin
                        valid_nxt_s  = 1'b1;
                        iabort_nxt_s = i_iabort;
                        taken_nxt_s  = i_taken;
                        pred_nxt_s   = i_pred;
                        pc_nxt_s     = i_word_pc;
                        if (!i_cpsr_ff_t) begin
                            instr_nxt_s = i_word;
                            pc8_nxt_s   = i_word_pc + 32'd8;
                        end else begin
                            instr_nxt_s = {16'd0, i_word_pc[1] ? i_word[31:16] : i_word[15:0]};
                            pc8_nxt_s   = i_word_pc + 32'd4;
`ifdef ZAP_THUMB_HW_REUSE_EN
                            // Only a sequential, non-aborted, predicted-not-taken lower half may reuse the upper half.
                            if (!i_word_pc[1] && !i_iabort && !i_taken[1]) begin
                                state_nxt_s    = HOLD;
                                buf_half_nxt_s = i_word[31:16];
                                buf_pc_nxt_s   = i_word_pc + 32'd2;
                                buf_pred_nxt_s = i_pred;
                            end else begin
                                state_nxt_s = EMPTY;
                            end
`endif
                        end
                    end
                end
`ifdef ZAP_THUMB_HW_REUSE_EN
                HOLD: begin
                    state_nxt_s = EMPTY;
                    if (i_cpsr_ff_t) begin
                        valid_nxt_s  = 1'b1;
                        instr_nxt_s  = {16'd0, buf_half_r};
                        pc_nxt_s     = buf_pc_r;
                        pc8_nxt_s    = buf_pc_r + 32'd4;
                        iabort_nxt_s = 1'b0;
                        taken_nxt_s  = 2'b01;
                        pred_nxt_s   = buf_pred_r;
                    end else begin
                        valid_nxt_s = 1'b0;
                    end
                end
`endif
                default: begin
                    state_nxt_s = EMPTY;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= EMPTY;
            instr_r  <= 32'd0;
            valid_r  <= 1'b0;
            iabort_r <= 1'b0;
            pc_r     <= 32'd0;
            pc8_r    <= 32'd0;
            taken_r  <= 2'd0;
            pred_r   <= 33'd0;
`ifdef ZAP_THUMB_HW_REUSE_EN
            buf_half_r <= 16'd0;
            buf_pc_r   <= 32'd0;
            buf_pred_r <= 33'd0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            instr_r  <= instr_nxt_s;
            valid_r  <= valid_nxt_s;
            iabort_r <= iabort_nxt_s;
            pc_r     <= pc_nxt_s;
            pc8_r    <= pc8_nxt_s;
            taken_r  <= taken_nxt_s;
            pred_r   <= pred_nxt_s;
`ifdef ZAP_THUMB_HW_REUSE_EN
            buf_half_r <= buf_half_nxt_s;
            buf_pc_r   <= buf_pc_nxt_s;
            buf_pred_r <= buf_pred_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_zap_thumb_fetch_aligner.sv
// Directed self-checking bench for zap_thumb_fetch_aligner; expectations follow ZAP_THUMB_HW_REUSE_EN.
module tb_zap_thumb_fetch_aligner;

`ifdef ZAP_THUMB_HW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode;
    logic        i_cpsr_ff_t, i_word_valid, i_iabort;
    logic [31:0] i_word, i_word_pc;
    logic [1:0]  i_taken;
    logic [32:0] i_pred;
    logic        o_word_ready, o_instruction_valid, o_iabort;
    logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic [1:0]  o_taken_ff;
    logic [32:0] o_pred;

    int err_cnt = 0;
    int chk_cnt = 0;

    zap_thumb_fetch_aligner dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .i_clear_from_decode(i_clear_from_decode), .i_cpsr_ff_t(i_cpsr_ff_t),
        .i_word(i_word), .i_word_valid(i_word_valid), .i_word_pc(i_word_pc),
        .i_iabort(i_iabort), .i_taken(i_taken), .i_pred(i_pred),
        .o_word_ready(o_word_ready), .o_instruction(o_instruction),
        .o_instruction_valid(o_instruction_valid), .o_iabort(o_iabort),
        .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff),
        .o_taken_ff(o_taken_ff), .o_pred(o_pred)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] pc8, input logic valid);
        check({tag, ".instr"}, 64'(o_instruction), 64'(instr));
        check({tag, ".pc"}, 64'(o_pc_ff), 64'(pc));
        check({tag, ".pc8"}, 64'(o_pc_plus_8_ff), 64'(pc8));
        check({tag, ".valid"}, 64'(o_instruction_valid), 64'(valid));
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic word_in(input logic t, input logic [31:0] w, input logic [31:0] pc,
                           input logic ab, input logic [1:0] tk, input logic [32:0] pr);
        i_cpsr_ff_t  = t;
        i_word       = w;
        i_word_pc    = pc;
        i_iabort     = ab;
        i_taken      = tk;
        i_pred       = pr;
        i_word_valid = 1'b1;
    endtask

    initial begin
        i_reset = 1'b1;
        i_clear_from_writeback = 1'b0; i_data_stall = 1'b0; i_clear_from_alu = 1'b0;
        i_stall_from_shifter = 1'b0; i_stall_from_issue = 1'b0; i_stall_from_decode = 1'b0;
        i_clear_from_decode = 1'b0; i_cpsr_ff_t = 1'b0; i_word_valid = 1'b0; i_iabort = 1'b0;
        i_word = 32'd0; i_word_pc = 32'd0; i_taken = 2'd0; i_pred = 33'd0;
        #1;
        step(); step(); step();
        i_reset = 1'b0;
        #1;
        check_out("reset", 32'd0, 32'd0, 32'd0, 1'b0);
        check("reset.iabort", 64'(o_iabort), 64'd0);
        check("reset.taken", 64'(o_taken_ff), 64'd0);
        check("reset.pred", 64'(o_pred), 64'd0);
        check("reset.ready", 64'(o_word_ready), 64'd1);

        // Thumb lower halfword, then buffered upper halfword or bubble.
        word_in(1'b1, 32'hB5104A03, 32'h100, 1'b0, 2'b00, 33'h1_0000_0200);
        step();
        check_out("t_lo", 32'h4A03, 32'h100, 32'h104, 1'b1);
        check("t_lo.taken", 64'(o_taken_ff), 64'd0);
        check("t_lo.pred", 64'(o_pred), 64'h1_0000_0200);
        i_word_valid = 1'b0;
        #1;
        check("t_lo.ready", 64'(o_word_ready), REUSE ? 64'd0 : 64'd1);
        step();
        if (REUSE) begin
            check_out("t_hi", 32'hB510, 32'h102, 32'h106, 1'b1);
            check("t_hi.taken", 64'(o_taken_ff), 64'd1);
            check("t_hi.pred", 64'(o_pred), 64'h1_0000_0200);
        end else begin
            check_out("t_hi", 32'h4A03, 32'h100, 32'h104, 1'b0);
        end
        check("t_hi.ready", 64'(o_word_ready), 64'd1);
        // Refetch at pc+2 selects the upper halfword.
        word_in(1'b1, 32'hB5104A03, 32'h102, 1'b0, 2'b00, 33'h0_0000_0040);
        step();
        check_out("t_refetch", 32'hB510, 32'h102, 32'h106, 1'b1);
        i_word_valid = 1'b0;
        #1;
        check("t_refetch.ready", 64'(o_word_ready), 64'd1);

        // Predicted taken: no HOLD.
        word_in(1'b1, 32'h11112222, 32'h100, 1'b0, 2'b10, 33'h0_0000_0800);
        step();
        check_out("t_taken", 32'h2222, 32'h100, 32'h104, 1'b1);
        check("t_taken.taken", 64'(o_taken_ff), 64'd2);
        i_word_valid = 1'b0;
        #1;
        check("t_taken.ready", 64'(o_word_ready), 64'd1);
        step();
        check("t_taken.bubble", 64'(o_instruction_valid), 64'd0);

        // Aborted fetch: no HOLD, then upper half fetched explicitly.
        word_in(1'b1, 32'h33334444, 32'h200, 1'b1, 2'b00, 33'd0);
        step();
        check_out("t_abt", 32'h4444, 32'h200, 32'h204, 1'b1);
        check("t_abt.iabort", 64'(o_iabort), 64'd1);
        word_in(1'b1, 32'h33334444, 32'h202, 1'b0, 2'b00, 33'd0);
        #1;
        check("t_abt.ready", 64'(o_word_ready), 64'd1);
        step();
        check_out("t_abt_hi", 32'h3333, 32'h202, 32'h206, 1'b1);
        check("t_abt_hi.iabort", 64'(o_iabort), 64'd0);
        i_word_valid = 1'b0;
        step();

        // Stall then decode clear while (possibly) holding a halfword.
        word_in(1'b1, 32'hB5104A03, 32'h300, 1'b0, 2'b00, 33'd0);
        step();
        i_word_valid = 1'b0;
        i_stall_from_issue = 1'b1;
        #1;
        check("stall.ready", 64'(o_word_ready), 64'd0);
        step(); step();
        check_out("stall2", 32'h4A03, 32'h300, 32'h304, 1'b1);
        i_stall_from_issue = 1'b0;
        i_clear_from_decode = 1'b1;
        step();
        check_out("clr_dec", 32'h4A03, 32'h300, 32'h304, 1'b0);
        i_clear_from_decode = 1'b0;
        #1;
        check("clr_dec.ready", 64'(o_word_ready), 64'd1);
        step();
        check("clr_dec.empty", 64'(o_instruction_valid), 64'd0);

        // ARM word with PC wrap; data stall outranks ALU clear.
        word_in(1'b0, 32'hE3A00001, 32'hFFFFFFF8, 1'b0, 2'b11, 33'h1_2345_6789);
        step();
        check_out("arm", 32'hE3A00001, 32'hFFFFFFF8, 32'h0, 1'b1);
        check("arm.taken", 64'(o_taken_ff), 64'd3);
        check("arm.pred", 64'(o_pred), 64'h1_2345_6789);
        word_in(1'b0, 32'h12345678, 32'h10, 1'b0, 2'b00, 33'd0);
        i_data_stall = 1'b1;
        i_clear_from_alu = 1'b1;
        step();
        check_out("dstall_alu", 32'hE3A00001, 32'hFFFFFFF8, 32'h0, 1'b1);
        i_data_stall = 1'b0;
        step();
        check_out("alu_clr", 32'hE3A00001, 32'hFFFFFFF8, 32'h0, 1'b0);
        i_clear_from_alu = 1'b0;

        // Thumb PC wrap on the buffered halfword.
        word_in(1'b1, 32'h5555AAAA, 32'hFFFFFFFC, 1'b0, 2'b01, 33'd5);
        step();
        check_out("wrap_lo", 32'hAAAA, 32'hFFFFFFFC, 32'h0, 1'b1);
        i_word_valid = 1'b0;
        step();
        check_out("wrap_hi", REUSE ? 32'h5555 : 32'hAAAA, REUSE ? 32'hFFFFFFFE : 32'hFFFFFFFC,
                  REUSE ? 32'h2 : 32'h0, REUSE);

        // Writeback clear beats data stall and forces iabort low.
        word_in(1'b0, 32'hCAFEF00D, 32'h40, 1'b1, 2'b00, 33'd0);
        step();
        check("wb.iabort_in", 64'(o_iabort), 64'd1);
        i_clear_from_writeback = 1'b1;
        i_data_stall = 1'b1;
        step();
        check_out("wb_clr", 32'hCAFEF00D, 32'h40, 32'h48, 1'b0);
        check("wb_clr.iabort", 64'(o_iabort), 64'd0);
        i_clear_from_writeback = 1'b0;
        i_data_stall = 1'b0;

        // ALU clear beats shifter stall; decode stall beats decode clear.
        word_in(1'b0, 32'h0BADBEEF, 32'h80, 1'b0, 2'b00, 33'd0);
        step();
        i_clear_from_alu = 1'b1;
        i_stall_from_shifter = 1'b1;
        step();
        check("alu_vs_shf.valid", 64'(o_instruction_valid), 64'd0);
        i_clear_from_alu = 1'b0;
        i_stall_from_shifter = 1'b0;
        step();
        check_out("refill", 32'h0BADBEEF, 32'h80, 32'h88, 1'b1);
        i_stall_from_decode = 1'b1;
        i_clear_from_decode = 1'b1;
        step();
        check_out("dec_stall", 32'h0BADBEEF, 32'h80, 32'h88, 1'b1);
        i_stall_from_decode = 1'b0;
        i_clear_from_decode = 1'b0;

        // Reset while a halfword may be buffered.
        word_in(1'b1, 32'h77776666, 32'h400, 1'b0, 2'b00, 33'd9);
        step();
        i_word_valid = 1'b0;
        i_reset = 1'b1;
        step();
        check_out("rst_hold", 32'd0, 32'd0, 32'd0, 1'b0);
        i_reset = 1'b0;
        step();
        check("rst_hold.after", 64'(o_instruction_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
